shift_reg_loopback_ctrl: RTL

Sequencer for the serial shift register (top_level, LENGTH stages). It accepts a parallel word over a valid/ready handshake and shifts it into the register LSB first. It then drains the register and rebuilds the word from the serial output, compares it with the original, and clears the register. The result and a mismatch flag are returned over a second valid/ready handshake. It serves as the in-system loopback self-test driver for the shift-register datapath.

---
 rtl/shift_reg_loopback_pkg.sv | 20 ++
 rtl/shift_reg_loopback_ctrl_capture.sv | 42 ++++
 rtl/shift_reg_loopback_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/shift_reg_loopback_pkg.sv
// Shared types and helpers for the shift-register loopback self-test controller.
//   state_t    : controller FSM states
//   clog2_len  : bit-counter width for a LENGTH-stage register (never below 1)
package shift_reg_loopback_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        DRAIN  = 3'd2,
        CLEAR  = 3'd3,
        RESULT = 3'd4
    } state_t;

    function automatic int clog2_len(input int len);
        int w;
        w = $clog2(len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/shift_reg_loopback_ctrl_capture.sv
// sr_bit_capture: bit counter plus serial-to-parallel deserializer.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   enable       : advance the counter (and capture bit_in at word[count])
//   clear        : force the counter back to 0
//   bit_in       : serial bit captured while enabled
//   count        : current bit index, 0..LENGTH-1
//   done         : enabled and on the last bit index this cycle
//   word         : deserialized word
module sr_bit_capture #(
    parameter int LENGTH = 32,
    parameter int CNT_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              bit_in,
    output logic [CNT_W-1:0]  count,
    output logic              done,
    output logic [LENGTH-1:0] word
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

    assign done = enable && (count == LAST);

    // The wrap back to 0 is explicit so a non-power-of-two LENGTH never
    // lets the index run past the last stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
            word  <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            word[count] <= bit_in;
            count       <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/shift_reg_loopback_ctrl.sv
// shift_reg_loopback_ctrl: loopback self-test sequencer for a LENGTH-stage
// serial shift register. Takes a word over valid/ready, shifts it in LSB
// first, drains it back out, compares, clears the register and returns the
// rebuilt word plus a mismatch flag over a second valid/ready handshake.
// Ports:
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_valid, o_ready, i_word: word request handshake (ready only in IDLE)
//   o_sr_din, o_sr_rst      : drive shift register serial input and reset
//   i_sr_dout               : shift register serial output
//   o_valid, i_ready        : result handshake
//   o_word, o_mismatch      : rebuilt word, differs-from-sent flag
//   o_busy                  : any state other than IDLE
//   o_err_count             : saturating count of mismatched results
//
// state  | meaning
// IDLE   | register held out of reset, waiting for a word
// FILL   | shifting tx_word in, one bit per cycle, LSB first
// DRAIN  | shifting zeros in, capturing the serial output into rx_word
// CLEAR  | register reset asserted; compare and publish the result
// RESULT | result valid, waiting for i_ready
module shift_reg_loopback_ctrl
    import shift_reg_loopback_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int ERR_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [LENGTH-1:0] i_word,
    output logic              o_sr_din,
    output logic              o_sr_rst,
    input  logic              i_sr_dout,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [LENGTH-1:0] o_word,
    output logic              o_mismatch,
    output logic              o_busy,
    output logic [ERR_W-1:0]  o_err_count
);

    localparam int CNT_W = clog2_len(LENGTH);

    state_t              state;
    logic [LENGTH-1:0]   tx_word;
    logic [LENGTH-1:0]   rx_word;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                cnt_done;
    logic                cap_en;
    logic                accept;
    logic                mismatch;

    assign accept   = (state == IDLE) && i_valid && o_ready;
    assign cap_en   = (state == FILL) || (state == DRAIN);
    assign cnt_nxt  = cnt + 1'b1;
    assign mismatch = (rx_word != tx_word);
    assign o_busy   = (state != IDLE);

    // The counter also captures during FILL; those bits are all overwritten
    // by DRAIN before rx_word is compared.
    sr_bit_capture #(
        .LENGTH (LENGTH),
        .CNT_W  (CNT_W)
    ) u_capture (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .enable (cap_en),
        .clear  (accept),
        .bit_in (i_sr_dout),
        .count  (cnt),
        .done   (cnt_done),
        .word   (rx_word)
    );

    // o_sr_din is registered one bit ahead: bit cnt is on the pin while the
    // counter reads cnt, so the register samples bits 0..LENGTH-1 on the
    // LENGTH edges following the accept edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            tx_word     <= '0;
            o_ready     <= 1'b0;
            o_sr_din    <= 1'b0;
            o_sr_rst    <= 1'b1;
            o_valid     <= 1'b0;
            o_word      <= '0;
            o_mismatch  <= 1'b0;
            o_err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_sr_rst <= 1'b0;
                    o_sr_din <= 1'b0;
                    if (accept) begin
                        tx_word  <= i_word;
                        o_sr_din <= i_word[0];
                        o_ready  <= 1'b0;
                        state    <= FILL;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt_done) begin
                        o_sr_din <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        o_sr_din <= tx_word[cnt_nxt];
                    end
                end
                DRAIN: begin
                    o_sr_din <= 1'b0;
                    if (cnt_done) begin
                        o_sr_rst <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    o_sr_rst   <= 1'b0;
                    o_word     <= rx_word;
                    o_mismatch <= mismatch;
                    if (mismatch && (o_err_count != '1)) begin
                        o_err_count <= o_err_count + 1'b1;
                    end
                    o_valid <= 1'b1;
                    state   <= RESULT;
                end
                RESULT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
